bg_compositor: RTL

- Downstream of the background ROM stage and the sprite ROMs.
- Takes 4-bit palette indices for background and sprite, applies transparency and priority, looks up a 16-entry writable RGB palette and produces registered 8-bit VGA colour.
- Owns the screen-transition fade FSM and drives `bg_sel` into the background stage, so scene swaps happen only while the screen is black.

---
 rtl/bg_compositor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bg_compositor.sv
// bg_compositor: background/sprite priority, writable RGB palette, fade scaling and
// the scene-transition fade FSM that only swaps bg_sel while the screen is black.
module bg_compositor #(
    parameter int FADE_STEP_FRAMES = 2,
    parameter int SCREEN_LENGTH    = 640,
    parameter int SCREEN_WIDTH     = 480
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [3:0]  req_bg,
    input  logic [3:0]  background_data,
    input  logic [3:0]  sprite_index,
    input  logic        sprite_valid,
    input  logic        pal_we,
    input  logic [3:0]  pal_addr,
    input  logic [23:0] pal_data,
    output logic [3:0]  bg_sel,
    output logic        fading,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);
    typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} state_t;

    localparam logic [9:0] X_END = 10'(SCREEN_LENGTH);
    localparam logic [9:0] Y_END = 10'(SCREEN_WIDTH);
    localparam logic [3:0] LAST  = 4'(FADE_STEP_FRAMES - 1);

    state_t      state_q, state_d;
    logic [4:0]  level_q, level_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  disp_q, disp_d;
    logic [9:0]  x_q, y_q;
    logic [7:0]  r_q, g_q, b_q, r_d, g_d, b_d;
    logic [23:0] pal_q [16];
    logic [23:0] rgb;
    logic [3:0]  idx;
    logic [12:0] prod_r, prod_g, prod_b;
    logic        vis, step;

    assign bg_sel = disp_q;
    assign fading = state_q != IDLE;
    assign VGA_R  = r_q;
    assign VGA_G  = g_q;
    assign VGA_B  = b_q;

    // Fade decisions happen only on frame_start so a frame never tears mid-scan.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        step    = cnt_q == LAST;
        if (frame_start) begin
            if (state_q == IDLE) begin
                if (req_bg != disp_q) begin
                    state_d = FADE_OUT;
                    cnt_d   = (LAST == 4'd0) ? 4'd0 : 4'd1;
                end
            end else begin
                cnt_d = step ? 4'd0 : cnt_q + 4'd1;
                if (step) begin
                    if (state_q == FADE_OUT || req_bg != disp_q) begin
                        state_d = FADE_OUT;
                        level_d = (level_q == 5'd0) ? 5'd0 : level_q - 5'd1;
                        if (level_q <= 5'd1) begin
                            disp_d  = req_bg;
                            state_d = FADE_IN;
                        end
                    end else begin
                        level_d = level_q + 5'd1;
                        state_d = (level_q == 5'd15) ? IDLE : FADE_IN;
                    end
                end
            end
        end
    end

    always_comb begin
        idx    = (sprite_valid && sprite_index != 4'd0) ? sprite_index : background_data;
        rgb    = pal_q[idx];
        vis    = (x_q < X_END) && (y_q < Y_END);
        prod_r = {5'd0, rgb[23:16]} * {8'd0, level_q};
        prod_g = {5'd0, rgb[15:8]}  * {8'd0, level_q};
        prod_b = {5'd0, rgb[7:0]}   * {8'd0, level_q};
        r_d    = vis ? prod_r[11:4] : 8'd0;
        g_d    = vis ? prod_g[11:4] : 8'd0;
        b_d    = vis ? prod_b[11:4] : 8'd0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            level_q <= 5'd16;
            cnt_q   <= 4'd0;
            disp_q  <= 4'd0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            r_q     <= 8'd0;
            g_q     <= 8'd0;
            b_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            x_q     <= DrawX;
            y_q     <= DrawY;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    // Lookups read the pre-write contents, so a same-cycle write shows up one pixel later.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 16; i++) pal_q[i] <= {3{8'(i * 17)}};
        end else if (pal_we) begin
            pal_q[pal_addr] <= pal_data;
        end
    end
endmodule
